// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 serial receiver: pulse-width bit decode, 24-bit GRB words, latch-gap frame detection.
// Optional WS2812_RX_GLITCH_FILTER_EN: din must be stable for 3 samples before the decoder sees an edge.
module ws2812_rx #(
  parameter int T1_MIN       = 13,
  parameter int HIGH_MIN     = 3,
  parameter int HIGH_MAX     = 30,
  parameter int RESET_CYCLES = 1250
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        din,
  output logic [23:0] data,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        latch,
  output logic [15:0] frame_pixels,
  output logic        err,
  output logic        overrun,
  input  logic        overrun_clr
);

  localparam int CW = $clog2(RESET_CYCLES + 1);

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;

  logic          din_m, din_s;
  logic          line, line_p;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [4:0]    bitcnt;
  logic [23:0]   shreg;
  logic [15:0]   word_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
    end
  end

`ifdef WS2812_RX_GLITCH_FILTER_EN
  // line follows din_s only once the current and two previous samples agree
  logic [1:0] hist;
  logic       line_q;

  assign line = (din_s == hist[0] && din_s == hist[1]) ? din_s : line_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist   <= 2'b00;
      line_q <= 1'b0;
    end else begin
      hist   <= {hist[0], din_s};
      line_q <= line;
    end
  end
`else
  assign line = din_s;
`endif

  logic        rise, fall, bit_val;
  logic [23:0] new_word;

  assign rise     = line & ~line_p;
  assign fall     = ~line & line_p;
  assign bit_val  = (cnt >= CW'(T1_MIN));
  assign new_word = {shreg[22:0], bit_val};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      line_p       <= 1'b0;
      state        <= S_SYNC;
      cnt          <= '0;
      bitcnt       <= 5'd0;
      shreg        <= 24'd0;
      word_cnt     <= 16'd0;
      data         <= 24'd0;
      data_valid   <= 1'b0;
      latch        <= 1'b0;
      frame_pixels <= 16'd0;
      err          <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      line_p <= line;
      latch  <= 1'b0;
      err    <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;
      if (overrun_clr) overrun <= 1'b0;

      case (state)
        S_SYNC: begin
          if (line) begin
            cnt <= '0;
          end else if (cnt == CW'(RESET_CYCLES - 1)) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_IDLE: begin
          if (rise) begin
            cnt   <= CW'(1);
            state <= S_HIGH;
          end
        end

        S_HIGH: begin
          if (cnt > CW'(HIGH_MAX) || (fall && cnt < CW'(HIGH_MIN))) begin
            err      <= 1'b1;
            bitcnt   <= 5'd0;
            shreg    <= 24'd0;
            word_cnt <= 16'd0;
            cnt      <= '0;
            state    <= S_SYNC;
          end else if (fall) begin
            shreg <= new_word;
            cnt   <= CW'(1);
            state <= S_LOW;
            if (bitcnt == 5'd23) begin
              bitcnt <= 5'd0;
              if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
              if (!data_valid || data_ready) begin
                data       <= new_word;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bitcnt <= bitcnt + 5'd1;
            end
          end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          if (rise) begin
            cnt   <= CW'(1);
            state <= S_HIGH;
          end else if (cnt == CW'(RESET_CYCLES)) begin
            latch        <= 1'b1;
            frame_pixels <= word_cnt;
            if (bitcnt != 5'd0) err <= 1'b1;
            bitcnt   <= 5'd0;
            shreg    <= 24'd0;
            word_cnt <= 16'd0;
            cnt      <= '0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - Directed self-checking bench for ws2812_rx (table of single-word frames plus corner sequences).
module tb_ws2812_rx;

  logic        clk = 1'b0;
  logic        resetn;
  logic        din;
  logic [23:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        latch;
  logic [15:0] frame_pixels;
  logic        err;
  logic        overrun;
  logic        overrun_clr;

  ws2812_rx dut (
    .clk          (clk),
    .resetn       (resetn),
    .din          (din),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .latch        (latch),
    .frame_pixels (frame_pixels),
    .err          (err),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

`ifdef WS2812_RX_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  int total = 0;
  int bad   = 0;

  int err_n = 0, latch_n = 0, both_n = 0, dv_rise_n = 0;
  logic [15:0] last_fp = 16'd0;
  logic        dv_prev = 1'b0;

  always @(negedge clk) begin
    if (err) err_n <= err_n + 1;
    if (latch) begin
      latch_n <= latch_n + 1;
      last_fp <= frame_pixels;
    end
    if (latch && err) both_n <= both_n + 1;
    if (data_valid && !dv_prev) dv_rise_n <= dv_rise_n + 1;
    dv_prev <= data_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    hold(1'b1, b ? 18 : 9);
    hold(1'b0, b ? 13 : 22);
  endtask

  // chk: verify data_valid timing and value against the falling edge of bit 24
  task automatic send_word(input logic [23:0] w, input bit chk);
    for (int i = 23; i >= 0; i--) begin
      if (chk && i == 0) begin
        hold(1'b1, w[0] ? 18 : 9);
        din = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
          @(posedge clk);
          #1;
          if (e == LAT - 1) check("lat_not_yet", {31'd0, data_valid}, 32'd0);
        end
        check("lat_valid", {31'd0, data_valid}, 32'd1);
        check("lat_data", {8'd0, data}, {8'd0, w});
        repeat ((w[0] ? 13 : 22) - LAT) @(posedge clk);
        #1;
      end else begin
        send_bit(w[i]);
      end
    end
  endtask

  typedef struct {
    logic [23:0] word;
    logic [23:0] exp_data;
    logic [15:0] exp_fp;
  } vec_t;

  vec_t vecs[5];
  int e0, l0, d0;

  initial begin
    vecs[0] = '{24'hFF00FF, 24'hFF00FF, 16'd1};
    vecs[1] = '{24'h000000, 24'h000000, 16'd1};
    vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 16'd1};
    vecs[3] = '{24'hA5C3E1, 24'hA5C3E1, 16'd1};
    vecs[4] = '{24'h800001, 24'h800001, 16'd1};

    resetn = 1'b0; din = 1'b0; data_ready = 1'b1; overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {data, data_valid, latch, err, overrun, 4'd0}, 32'd0);
    check("reset_fp", {16'd0, frame_pixels}, 32'd0);
    resetn = 1'b1;
    hold(1'b0, 1300);
    check("sync_no_latch", latch_n, 0);

    for (int v = 0; v < 5; v++) begin
      e0 = err_n; l0 = latch_n;
      send_word(vecs[v].word, 1'b1);
      hold(1'b0, 1300);
      check("tbl_data_held", {8'd0, data}, {8'd0, vecs[v].exp_data});
      check("tbl_latch", latch_n - l0, 1);
      check("tbl_fp", {16'd0, last_fp}, {16'd0, vecs[v].exp_fp});
      check("tbl_fp_held", {16'd0, frame_pixels}, {16'd0, vecs[v].exp_fp});
      check("tbl_no_err", err_n - e0, 0);
      check("tbl_valid_consumed", {31'd0, data_valid}, 32'd0);
    end

    // overrun: second word arrives while first still unconsumed
    data_ready = 1'b0;
    e0 = err_n; l0 = latch_n;
    send_word(24'h123456, 1'b0);
    send_word(24'hABCDEF, 1'b0);
    check("ovr_data", {8'd0, data}, 32'h00123456);
    check("ovr_valid", {31'd0, data_valid}, 32'd1);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    check("ovr_clr", {31'd0, overrun}, 32'd0);
    data_ready = 1'b1;
    @(posedge clk); #1;
    check("ovr_consume", {31'd0, data_valid}, 32'd0);
    hold(1'b0, 1300);
    check("ovr_latch", latch_n - l0, 1);
    check("ovr_fp", {16'd0, last_fp}, 32'd2);
    check("ovr_no_err", err_n - e0, 0);

    // partial frame: 10 bits then latch gap
    e0 = err_n; l0 = latch_n; d0 = dv_rise_n;
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    hold(1'b0, 1300);
    check("part_latch", latch_n - l0, 1);
    check("part_err", err_n - e0, 1);
    check("part_same_cycle", both_n, 1);
    check("part_fp", {16'd0, last_fp}, 32'd0);
    check("part_no_valid", dv_rise_n - d0, 0);

    // over-long high pulse mid-word
    e0 = err_n; l0 = latch_n;
    for (int i = 0; i < 5; i++) send_bit(~i[0]);
    hold(1'b1, 40);
    hold(1'b0, 13);
    check("long_err", err_n - e0, 1);
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    hold(1'b0, 1300);
    check("long_ignored_err", err_n - e0, 1);
    check("long_no_latch", latch_n - l0, 0);
    l0 = latch_n;
    send_word(24'h00FF00, 1'b1);
    hold(1'b0, 1300);
    check("recover_data", {8'd0, data}, 32'h0000FF00);
    check("recover_latch", latch_n - l0, 1);
    check("recover_fp", {16'd0, last_fp}, 32'd1);

    // 1-cycle spike between bits
    e0 = err_n; l0 = latch_n;
    for (int i = 23; i >= 12; i--) send_bit(vecs[3].word[i]);
    hold(1'b0, 5);
    hold(1'b1, 1);
    hold(1'b0, 10);
    for (int i = 11; i >= 0; i--) send_bit(vecs[3].word[i]);
    hold(1'b0, 1300);
`ifdef WS2812_RX_GLITCH_FILTER_EN
    check("spike_err", err_n - e0, 0);
    check("spike_latch", latch_n - l0, 1);
    check("spike_data", {8'd0, data}, 32'h00A5C3E1);
`else
    check("spike_err", err_n - e0, 1);
    check("spike_latch", latch_n - l0, 0);
    check("spike_data_kept", {8'd0, data}, 32'h0000FF00);
`endif

    // asynchronous reset mid-word
    e0 = err_n; l0 = latch_n;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    din = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    din = 1'b0;
    #1;
    check("rst_mid_outputs", {data, data_valid, latch, err, overrun, 4'd0}, 32'd0);
    check("rst_mid_fp", {16'd0, frame_pixels}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    check("rst_no_pulses", (err_n - e0) + (latch_n - l0), 0);
    d0 = dv_rise_n;
    hold(1'b0, 100);
    send_word(24'h5A5A5A, 1'b0);
    hold(1'b0, 1300);
    check("rst_sync_ignores", dv_rise_n - d0, 0);
    check("rst_sync_no_latch", latch_n - l0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
